// File: rtl/lc3_ea_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : lc3_ea_sequencer
// Description : LC-3 effective-address sequencer. Latches one instruction's
//               IR/PC/BaseR, forms base + SEXT(offset) per opcode, performs
//               the indirect pointer read for LDI/STI through a req/ack port,
//               and delivers EA (or an error) on a valid/ready handshake.
// Ports       : Clk, Reset (sync, active-high)
//               ir_valid/ir_ready, IR, PC, BaseR        - operand input
//               mem_req/mem_addr/mem_ack/mem_rdata      - indirect read port
//               ea_valid/ea_ready, EA, ea_err           - result output
//               op_count                                - completed-op counter
// Parameters  : MEM_TIMEOUT - cycles mem_req may wait for mem_ack
// Macros      : EA_COUNT_EN - builds the op_count counter; otherwise tied to 0
// Revision    : 1.0 - initial release
//==============================================================================
module lc3_ea_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ir_valid,
  output logic        ir_ready,
  input  logic [15:0] IR,
  input  logic [15:0] PC,
  input  logic [15:0] BaseR,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        ea_valid,
  input  logic        ea_ready,
  output logic [15:0] EA,
  output logic        ea_err,
  output logic [15:0] op_count
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_IND  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      base_q, base_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      ea_q, ea_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Opcode decode and address adder on the latched instruction
  logic [15:0] w_base;
  logic [15:0] w_off;
  logic [15:0] w_sum;
  logic        w_illegal;
  logic        w_ind;

  always_comb begin
    w_base    = pc_q;
    w_off     = {{7{ir_q[8]}}, ir_q[8:0]};
    w_illegal = 1'b0;
    w_ind     = 1'b0;
    unique case (ir_q[15:12])
      4'b0000, 4'b0010, 4'b0011, 4'b1110: ;           // BR, LD, ST, LEA
      4'b1010, 4'b1011: w_ind = 1'b1;                 // LDI, STI
      4'b0100: begin                                  // JSR / JSRR
        if (ir_q[11]) begin
          w_off = {{5{ir_q[10]}}, ir_q[10:0]};
        end else begin
          w_base = base_q;
          w_off  = 16'h0000;
        end
      end
      4'b1100: begin                                  // JMP / RET
        w_base = base_q;
        w_off  = 16'h0000;
      end
      4'b0110, 4'b0111: begin                         // LDR, STR
        w_base = base_q;
        w_off  = {{10{ir_q[5]}}, ir_q[5:0]};
      end
      default: w_illegal = 1'b1;
    endcase
    w_sum = w_base + w_off;                           // wraps mod 2^16
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    ea_d       = ea_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ir_valid) begin
          ir_d    = IR;
          pc_d    = PC;
          base_d  = BaseR;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (w_illegal) begin
          ea_d    = 16'h0000;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (w_ind) begin
          mem_addr_d = w_sum;
          cnt_d      = '0;
          state_d    = S_IND;
        end else begin
          ea_d    = w_sum;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_IND: begin
        // An ack in the final wait cycle still completes the read
        if (mem_ack) begin
          ea_d    = mem_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == C_CNT_LAST) begin
          ea_d    = 16'h0000;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (ea_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      ir_q       <= 16'h0000;
      pc_q       <= 16'h0000;
      base_q     <= 16'h0000;
      mem_addr_q <= 16'h0000;
      ea_q       <= 16'h0000;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      ea_q       <= ea_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ir_ready = (state_q == S_IDLE);
  assign mem_req  = (state_q == S_IND);
  assign ea_valid = (state_q == S_DONE);
  assign mem_addr = mem_addr_q;
  assign EA       = ea_q;
  assign ea_err   = err_q;

`ifdef EA_COUNT_EN
  // Counts only successful result handshakes
  logic [15:0] count_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= 16'h0000;
    end else if ((state_q == S_DONE) && ea_ready && !err_q) begin
      count_q <= count_q + 16'h0001;
    end
  end

  assign op_count = count_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc3_ea_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_lc3_ea_sequencer
// Description : Self-checking bench for lc3_ea_sequencer. Directed cases from
//               the LC-3 addressing rules, then randomized instructions, all
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_lc3_ea_sequencer;

  localparam int C_TO = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] IR;
  logic [15:0] PC;
  logic [15:0] BaseR;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ea_valid;
  logic        ea_ready;
  logic [15:0] EA;
  logic        ea_err;
  logic [15:0] op_count;

  int n_chk  = 0;
  int n_err  = 0;
  int n_good = 0;

  lc3_ea_sequencer #(.MEM_TIMEOUT(C_TO)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .IR       (IR),
    .PC       (PC),
    .BaseR    (BaseR),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ea_valid (ea_valid),
    .ea_ready (ea_ready),
    .EA       (EA),
    .ea_err   (ea_err),
    .op_count (op_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed offsets as plain integers, result truncated to 16 bits
  function automatic void model(input logic [15:0] ir, input logic [15:0] pc,
                                input logic [15:0] base, output logic [15:0] sum,
                                output bit ind, output bit err);
    int off;
    sum = 16'h0000;
    ind = 1'b0;
    err = 1'b0;
    case (int'(ir[15:12]))
      0, 2, 3, 14, 10, 11: begin
        off = int'(ir[8:0]);
        if (off >= 256) off = off - 512;
        sum = 16'(int'(pc) + off);
        ind = (ir[15:12] == 4'd10) || (ir[15:12] == 4'd11);
      end
      4: begin
        if (ir[11]) begin
          off = int'(ir[10:0]);
          if (off >= 1024) off = off - 2048;
          sum = 16'(int'(pc) + off);
        end else begin
          sum = base;
        end
      end
      12: sum = base;
      6, 7: begin
        off = int'(ir[5:0]);
        if (off >= 32) off = off - 64;
        sum = 16'(int'(base) + off);
      end
      default: err = 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef EA_COUNT_EN
    return 16'(n_good);
`else
    return 16'h0000;
`endif
  endfunction

  // One full instruction: accept, optional indirect read acked after ack_dly
  // request cycles (>= C_TO means never), then result held for rdy_dly cycles.
  task automatic do_op(input logic [15:0] ir, input logic [15:0] pc,
                       input logic [15:0] base, input int ack_dly,
                       input logic [15:0] rdata, input int rdy_dly);
    logic [15:0] sum;
    logic [15:0] x_ea;
    bit          ind;
    bit          x_err;
    int          n;
    int          k;
    model(ir, pc, base, sum, ind, x_err);
    x_ea = x_err ? 16'h0000 : sum;

    n = 0;
    while (!ir_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("ir_ready_idle", ir_ready, 1);
    IR = ir; PC = pc; BaseR = base; ir_valid = 1'b1;
    @(negedge Clk);
    // operands must already be latched
    ir_valid = 1'b0; IR = 16'($urandom); PC = 16'($urandom); BaseR = 16'($urandom);
    chk("calc_ea_valid", ea_valid, 0);
    chk("calc_ir_ready", ir_ready, 0);
    @(negedge Clk);

    if (ind && !x_err) begin
      chk("ind_mem_req", mem_req, 1);
      chk("ind_mem_addr", mem_addr, sum);
      k = 0;
      while (!ea_valid && k <= 100) begin
        if (k == ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
        @(negedge Clk);
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        k++;
        if (!ea_valid) begin
          chk("ind_req_held", mem_req, 1);
          chk("ind_addr_held", mem_addr, sum);
        end
      end
      if (ack_dly < C_TO) begin
        x_ea = rdata;
        chk("ind_cycles", k, ack_dly + 1);
      end else begin
        x_ea = 16'h0000;
        x_err = 1'b1;
        chk("timeout_cycles", k, C_TO);
      end
    end

    chk("done_ea_valid", ea_valid, 1);
    chk("done_ea", EA, x_ea);
    chk("done_err", ea_err, x_err);
    chk("done_mem_req", mem_req, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge Clk);
      chk("hold_valid", ea_valid, 1);
      chk("hold_ea", EA, x_ea);
      chk("hold_err", ea_err, x_err);
    end
    ea_ready = 1'b1;
    @(negedge Clk);
    ea_ready = 1'b0;
    if (!x_err) n_good++;
    chk("post_valid", ea_valid, 0);
    chk("post_err", ea_err, 0);
    chk("post_ir_ready", ir_ready, 1);
    chk("op_count", op_count, exp_count());
  endtask

  initial begin
    Reset = 1'b1; ir_valid = 1'b0; IR = '0; PC = '0; BaseR = '0;
    mem_ack = 1'b0; mem_rdata = '0; ea_ready = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ea_valid", ea_valid, 0);
    chk("rst_ea", EA, 0);
    chk("rst_err", ea_err, 0);
    chk("rst_op_count", op_count, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_ir_ready", ir_ready, 1);

    // Directed cases
    do_op(16'h21FF, 16'h3001, 16'h0000, 0, 16'h0000, 0);          // LD
    do_op(16'h6460, 16'h0000, 16'h0010, 0, 16'h0000, 1);          // LDR wrap
    do_op(16'hA002, 16'h3000, 16'h0000, 3, 16'h4000, 0);          // LDI
    do_op(16'hB002, 16'h3000, 16'h0000, 999, 16'h0000, 0);        // STI timeout
    do_op(16'hD000, 16'h1234, 16'h5678, 0, 16'h0000, 5);          // reserved
    chk("count_3_good", op_count, exp_count());
    do_op(16'hA1FF, 16'h8000, 16'h0000, C_TO - 1, 16'hBEEF, 2);   // ack on last cycle
    do_op(16'h4C00, 16'h0400, 16'h0000, 0, 16'h0000, 0);          // JSR -1024
    do_op(16'h4080, 16'h0000, 16'hCAFE, 0, 16'h0000, 0);          // JSRR
    do_op(16'hC1C0, 16'h0000, 16'h1357, 0, 16'h0000, 0);          // RET
    do_op(16'h1042, 16'h0000, 16'h0000, 0, 16'h0000, 0);          // ADD illegal

    // Randomized instructions
    for (int t = 0; t < 40; t++) begin
      do_op(16'($urandom), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 20)), 16'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset while waiting on the indirect read
    IR = 16'hA010; PC = 16'h2000; ir_valid = 1'b1;
    @(negedge Clk);
    ir_valid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("mid_req_before", mem_req, 1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_valid", ea_valid, 0);
    chk("mid_rst_ready", ir_ready, 1);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_count", op_count, 0);
    n_good = 0;
    Reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge Clk);
    mem_ack = 1'b0;
    chk("late_ack_valid", ea_valid, 0);
    chk("late_ack_ready", ir_ready, 1);
    do_op(16'h2E05, 16'h0100, 16'h0000, 0, 16'h0000, 0);          // LD after reset

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
